// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Pixel-clock divider, horizontal/vertical raster counters and registered
//   colour/sync/display-enable outputs for a VGA DAC.
//
//   Ports
//     clock        system clock (only clock)
//     reset        asynchronous, active-high
//     color        {R,G,B} for the pixel currently at x,y
//     x, y         raw raster counters (valid also during blanking)
//     R, G, B      registered colour, forced to 0 outside the active area
//     HS, VS       registered syncs, asserted level HS_POL / VS_POL
//     de           registered display enable, aligned with R/G/B
//     pix_tick     one-clock strobe, every CLK_DIV clocks
//     frame_start  one-clock pulse when pixel (0,0) appears on R/G/B
//
//   Optional feature: define VGA_BORDER_EN to force all-ones colour on the
//   outermost ring of active pixels (first/last column and row).
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   CLK_DIV  = 2,
  parameter int   COLOR_W  = 4,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   XY_W     = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [3*COLOR_W-1:0] color,
  output logic [XY_W-1:0]      x,
  output logic [XY_W-1:0]      y,
  output logic [COLOR_W-1:0]   R,
  output logic [COLOR_W-1:0]   G,
  output logic [COLOR_W-1:0]   B,
  output logic                 HS,
  output logic                 VS,
  output logic                 de,
  output logic                 pix_tick,
  output logic                 frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  // Sync-window bounds carry one spare bit so a window ending exactly at
  // 2**XY_W (zero back porch) does not wrap to 0.
  localparam int XW      = XY_W + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [XY_W-1:0]  H_LAST   = XY_W'(H_TOTAL - 1);
  localparam logic [XY_W-1:0]  V_LAST   = XY_W'(V_TOTAL - 1);
  localparam logic [XY_W-1:0]  H_ACT    = XY_W'(H_ACTIVE);
  localparam logic [XY_W-1:0]  V_ACT    = XY_W'(V_ACTIVE);
  localparam logic [XW-1:0]    HS_BEG   = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0]    HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [XW-1:0]    VS_BEG   = XW'(V_ACTIVE + V_FP);
  localparam logic [XW-1:0]    VS_END   = XW'(V_ACTIVE + V_FP + V_SYNC);
`ifdef VGA_BORDER_EN
  localparam logic [XY_W-1:0]  H_ACT_LAST = XY_W'(H_ACTIVE - 1);
  localparam logic [XY_W-1:0]  V_ACT_LAST = XY_W'(V_ACTIVE - 1);
`endif

  logic [DIV_W-1:0]     div_cnt;
  logic [XY_W-1:0]      h_cnt, v_cnt;
  logic                 active, hs_now, vs_now;
  logic [3*COLOR_W-1:0] pix;

  // Pixel divider. With CLK_DIV=1 the counter is stuck at 0 and the tick is
  // permanently high; the reset term keeps it low while reset is held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                    div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                          div_cnt <= div_cnt + 1'b1;
  end

  assign pix_tick = (div_cnt == DIV_LAST) & ~reset;
  assign x        = h_cnt;
  assign y        = v_cnt;

  // Decode of the pixel currently addressed; registered on the tick that
  // leaves it, giving one pixel of latency from x/y to the outputs.
  always_comb begin
    active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_now = (({1'b0, h_cnt} >= HS_BEG) && ({1'b0, h_cnt} < HS_END)) ? HS_POL : ~HS_POL;
    vs_now = (({1'b0, v_cnt} >= VS_BEG) && ({1'b0, v_cnt} < VS_END)) ? VS_POL : ~VS_POL;
    pix    = color;
`ifdef VGA_BORDER_EN
    if (h_cnt == '0 || h_cnt == H_ACT_LAST || v_cnt == '0 || v_cnt == V_ACT_LAST)
      pix = '1;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      R           <= '0;
      G           <= '0;
      B           <= '0;
      de          <= 1'b0;
      HS          <= ~HS_POL;
      VS          <= ~VS_POL;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_tick) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
        de          <= active;
        {R, G, B}   <= active ? pix : '0;
        HS          <= hs_now;
        VS          <= vs_now;
        // Pixel (0,0) reaches R/G/B on this very edge.
        frame_start <= (h_cnt == '0) && (v_cnt == '0);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. Three instances share clock/reset/color:
//   u_def : all defaults (640x480, CLK_DIV=2)
//   u_med : default horizontal timing, 7-line frame (V 3/1/2/1) so whole
//           frames fit in a short run
//   u_sml : CLK_DIV=1, H 8/2/2/2, V 4/1/1/1, HS_POL=1 (14x7 raster)
// Outputs are sampled on the falling edge; inputs driven on the falling edge.
module tb_vga_timing_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] color;

  always #5 clock = ~clock;

  logic [9:0] dx, dy;
  logic [3:0] dr, dg, db;
  logic       dhs, dvs, dde, dtick, dfs;

  logic [9:0] mx, my;
  logic [3:0] mr, mg, mb;
  logic       mhs, mvs, mde, mtick, mfs;

  logic [3:0] sx, sy;
  logic [3:0] sr, sg, sb;
  logic       shs, svs, sde, stick, sfs;

  int n_cmp  = 0;
  int n_fail = 0;

  vga_timing_gen u_def (
    .clock(clock), .reset(reset), .color(color), .x(dx), .y(dy),
    .R(dr), .G(dg), .B(db), .HS(dhs), .VS(dvs), .de(dde),
    .pix_tick(dtick), .frame_start(dfs)
  );

  vga_timing_gen #(.V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_med (
    .clock(clock), .reset(reset), .color(color), .x(mx), .y(my),
    .R(mr), .G(mg), .B(mb), .HS(mhs), .VS(mvs), .de(mde),
    .pix_tick(mtick), .frame_start(mfs)
  );

  vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .HS_POL(1'b1), .XY_W(4)) u_sml (
    .clock(clock), .reset(reset), .color(color), .x(sx), .y(sy),
    .R(sr), .G(sg), .B(sb), .HS(shs), .VS(svs), .de(sde),
    .pix_tick(stick), .frame_start(sfs)
  );

  task automatic test_reset;
    reset = 1'b0;
    color = 12'hfff;
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if ({dx, dy} !== 20'd0) begin
      n_fail++; $display("FAIL reset_xy: got x=%0d y=%0d want 0 0", dx, dy);
    end
    n_cmp++;
    if ({dr, dg, db, dde, dfs, dtick} !== 15'd0) begin
      n_fail++; $display("FAIL reset_outs: got rgb=%h de=%b fs=%b tick=%b want 0", {dr, dg, db}, dde, dfs, dtick);
    end
    n_cmp++;
    if ({dhs, dvs} !== 2'b11) begin
      n_fail++; $display("FAIL reset_sync: got HS=%b VS=%b want 1 1", dhs, dvs);
    end
    n_cmp++;
    if ({shs, svs, stick} !== 3'b010) begin
      n_fail++; $display("FAIL reset_sml: got HS=%b VS=%b tick=%b want 0 1 0", shs, svs, stick);
    end
    reset = 1'b0;
  endtask

  task automatic test_pix_tick;
    int cnt;
    @(negedge clock);
    n_cmp++;
    if ({dtick, dx, dfs} !== {1'b1, 10'd0, 1'b0}) begin
      n_fail++; $display("FAIL first_tick: got tick=%b x=%0d fs=%b want 1 0 0", dtick, dx, dfs);
    end
    n_cmp++;
    if ({stick, sx, sfs} !== {1'b1, 4'd1, 1'b1}) begin
      n_fail++; $display("FAIL sml_first: got tick=%b x=%0d fs=%b want 1 1 1", stick, sx, sfs);
    end
    @(negedge clock);
    n_cmp++;
    if ({dtick, dx, dfs, dde, dr} !== {1'b0, 10'd1, 1'b1, 1'b1, 4'hf}) begin
      n_fail++; $display("FAIL first_pixel: got tick=%b x=%0d fs=%b de=%b R=%h want 0 1 1 1 f", dtick, dx, dfs, dde, dr);
    end
    n_cmp++;
    if ({stick, sx, sfs} !== {1'b1, 4'd2, 1'b0}) begin
      n_fail++; $display("FAIL sml_second: got tick=%b x=%0d fs=%b want 1 2 0", stick, sx, sfs);
    end
    cnt = 0;
    repeat (20) begin
      @(negedge clock);
      if (dtick) cnt++;
    end
    n_cmp++;
    if (cnt != 10) begin
      n_fail++; $display("FAIL tick_period: got %0d ticks in 20 clocks want 10", cnt);
    end
  endtask

  task automatic test_line_wrap;
    bit found = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (dx == 10'd799) begin found = 1; break; end
    end
    n_cmp++;
    if (!found) begin
      n_fail++; $display("FAIL wait_x799: timeout, x=%0d want 799", dx);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (dx != 10'd799) break;
    end
    n_cmp++;
    if ({dx, dy} !== {10'd0, 10'd1}) begin
      n_fail++; $display("FAIL x_wrap: got x=%0d y=%0d want 0 1", dx, dy);
    end
  endtask

  // One full active line of the default instance, starting with x just 0.
  task automatic test_hsync_line;
    int cnt = 0, hs_lo = 0, hs_x = -1, de_hi = 0, rgb_bad = 0, hold_bad = 0;
    logic [9:0]  px = dx;
    logic        ptick = dtick;
    logic [14:0] prev = {dr, dg, db, dhs, dvs, dde};
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      cnt++;
      if (!dhs) begin
        hs_lo++;
        if (hs_x < 0) hs_x = int'(dx);
      end
      if (dde) de_hi++;
      if (!dde && {dr, dg, db} != 12'h000) rgb_bad++;
      if (!ptick && {dr, dg, db, dhs, dvs, dde} != prev) hold_bad++;
      prev  = {dr, dg, db, dhs, dvs, dde};
      ptick = dtick;
      if (dx == 10'd0 && px == 10'd799) break;
      px = dx;
    end
    n_cmp++;
    if (cnt != 1600) begin
      n_fail++; $display("FAIL line_period: got %0d clocks want 1600", cnt);
    end
    n_cmp++;
    if (hs_lo != 192) begin
      n_fail++; $display("FAIL hs_width: got %0d clocks low want 192", hs_lo);
    end
    n_cmp++;
    if (hs_x != 657) begin
      n_fail++; $display("FAIL hs_start: HS first low with x=%0d want 657 (pixel 656)", hs_x);
    end
    n_cmp++;
    if (de_hi != 1280) begin
      n_fail++; $display("FAIL de_line: got %0d clocks high want 1280", de_hi);
    end
    n_cmp++;
    if (rgb_bad != 0) begin
      n_fail++; $display("FAIL rgb_blank: got %0d nonzero samples with de=0 want 0", rgb_bad);
    end
    n_cmp++;
    if (hold_bad != 0) begin
      n_fail++; $display("FAIL out_hold: got %0d changes without tick want 0", hold_bad);
    end
  endtask

  // One whole frame of u_med, frame_start to frame_start.
  task automatic test_frame;
    bit found = 0;
    int cnt = 0, vs_lo = 0, vs_y = -1, hs_lo = 0, de_hi = 0, rgb_bad = 0;
    for (int i = 0; i < 12000; i++) begin
      @(negedge clock);
      if (mfs) begin found = 1; break; end
    end
    n_cmp++;
    if (!found) begin
      n_fail++; $display("FAIL wait_fs_med: timeout, fs=%b want 1", mfs);
    end
    for (int i = 0; i < 12000; i++) begin
      @(negedge clock);
      cnt++;
      if (!mvs) begin
        vs_lo++;
        if (vs_y < 0) vs_y = int'(my);
      end
      if (!mhs) hs_lo++;
      if (mde) de_hi++;
      if (!mde && {mr, mg, mb} != 12'h000) rgb_bad++;
      if (mfs) break;
    end
    n_cmp++;
    if (cnt != 11200) begin
      n_fail++; $display("FAIL frame_period: got %0d clocks want 11200", cnt);
    end
    n_cmp++;
    if (vs_lo != 3200 || vs_y != 4) begin
      n_fail++; $display("FAIL vsync: got %0d clocks low first y=%0d want 3200 4", vs_lo, vs_y);
    end
    n_cmp++;
    if (hs_lo != 1344) begin
      n_fail++; $display("FAIL hs_frame: got %0d clocks low want 1344", hs_lo);
    end
    n_cmp++;
    if (de_hi != 3840 || rgb_bad != 0) begin
      n_fail++; $display("FAIL de_frame: got de %0d clocks, %0d blank rgb errors want 3840 0", de_hi, rgb_bad);
    end
  endtask

  task automatic test_reset_mid;
    bit found = 0;
    int cnt = 0, first = -1;
    for (int i = 0; i < 12000; i++) begin
      @(negedge clock);
      if (mx == 10'd300 && my == 10'd2) begin found = 1; break; end
    end
    n_cmp++;
    if (!found) begin
      n_fail++; $display("FAIL wait_mid: timeout, x=%0d y=%0d want 300 2", mx, my);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({mx, my, mr, mg, mb, mde, mfs, mtick} !== 35'd0 || {mhs, mvs} !== 2'b11) begin
      n_fail++; $display("FAIL async_reset: got x=%0d y=%0d rgb=%h de=%b HS=%b VS=%b want 0 0 000 0 1 1",
                         mx, my, {mr, mg, mb}, mde, mhs, mvs);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 23000; i++) begin
      @(negedge clock);
      cnt++;
      if (mfs) begin
        if (first < 0) first = cnt;
        else break;
      end
    end
    n_cmp++;
    if (first != 2) begin
      n_fail++; $display("FAIL restart_fs: first frame_start after %0d clocks want 2", first);
    end
    n_cmp++;
    if (cnt != 11202) begin
      n_fail++; $display("FAIL restart_frame: second frame_start after %0d clocks want 11202", cnt);
    end
  endtask

  // Line 1 of u_med with color 5a3; first/last columns forced white only
  // when the border option is compiled in.
  task automatic test_border;
    bit found = 0;
    int n = 0, bad = 0;
    logic [11:0] got0 = 12'h0, got1 = 12'h0, got639 = 12'h0, exp_p;
    logic [11:0] exp_edge = 12'h5a3;
`ifdef VGA_BORDER_EN
    exp_edge = 12'hfff;
`endif
    color = 12'h5a3;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (my == 10'd1) begin found = 1; break; end
    end
    n_cmp++;
    if (!found) begin
      n_fail++; $display("FAIL wait_line1: timeout, y=%0d want 1", my);
    end
    for (int i = 0; i < 2000 && my == 10'd1; i++) begin
      if (mtick && mx >= 10'd1 && mx <= 10'd640) begin
        int p = int'(mx) - 1;
        exp_p = (p == 0 || p == 639) ? exp_edge : 12'h5a3;
        n++;
        if ({mr, mg, mb} != exp_p || !mde) bad++;
        if (p == 0)   got0   = {mr, mg, mb};
        if (p == 1)   got1   = {mr, mg, mb};
        if (p == 639) got639 = {mr, mg, mb};
      end
      @(negedge clock);
    end
    n_cmp++;
    if (got0 !== exp_edge || got639 !== exp_edge) begin
      n_fail++; $display("FAIL border_edges: got x0=%h x639=%h want %h", got0, got639, exp_edge);
    end
    n_cmp++;
    if (got1 !== 12'h5a3) begin
      n_fail++; $display("FAIL border_inner: got x1=%h want 5a3", got1);
    end
    n_cmp++;
    if (n != 640 || bad != 0) begin
      n_fail++; $display("FAIL border_line: got %0d pixels %0d wrong want 640 0", n, bad);
    end
    color = 12'hfff;
  endtask

  task automatic test_small;
    bit found = 0;
    int cnt = 0, hs_hi = 0, hs_x = -1, vs_lo = 0, de_hi = 0, rgb_bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (sfs) begin found = 1; break; end
    end
    n_cmp++;
    if (!found || {sx, sy} !== 8'h10) begin
      n_fail++; $display("FAIL sml_fs: found=%0d x=%0d y=%0d want 1 1 0", found, sx, sy);
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      cnt++;
      if (shs) begin
        hs_hi++;
        if (hs_x < 0) hs_x = int'(sx);
      end
      if (!svs) vs_lo++;
      if (sde) de_hi++;
      if (!sde && {sr, sg, sb} != 12'h000) rgb_bad++;
      if (sfs) break;
    end
    n_cmp++;
    if (cnt != 98) begin
      n_fail++; $display("FAIL sml_frame: got %0d clocks want 98", cnt);
    end
    n_cmp++;
    if (hs_hi != 14 || hs_x != 11) begin
      n_fail++; $display("FAIL sml_hs: got %0d clocks high first x=%0d want 14 11", hs_hi, hs_x);
    end
    n_cmp++;
    if (vs_lo != 14 || de_hi != 32 || rgb_bad != 0) begin
      n_fail++; $display("FAIL sml_vs_de: got vs_lo=%0d de=%0d rgb_err=%0d want 14 32 0", vs_lo, de_hi, rgb_bad);
    end
  endtask

  initial begin
    test_reset;
    test_pix_tick;
    test_line_wrap;
    test_hsync_line;
    test_frame;
    test_reset_mid;
    test_border;
    test_small;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
